// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// MEM/WB pipe and the FFT result channel. The pipe wins by default. An older
// FFT result to the same register goes first. A starvation counter forces a
// waiting FFT result through after STARVE lost arbitrations.
//
// Handshakes: the FFT channel is valid/ready. fft_valid, fft_wr_reg and
// fft_data stay stable until the cycle in which fft_ready is high, and that
// cycle is the transfer. The pipe has no ready signal. A pipe request with
// pipe_stall low is consumed. With pipe_stall high the pipe holds its values
// and presents them again on the next cycle.
module wb_port_arbiter #(
  parameter int INW    = 512,
  parameter int REGW   = 3,
  parameter int STARVE = 4,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic            pipe_reg_wr_en,
  input  logic [REGW-1:0] pipe_wr_reg,
  input  logic [INW-1:0]  pipe_data,
  output logic            pipe_stall,
  input  logic            fft_valid,
  input  logic [REGW-1:0] fft_wr_reg,
  input  logic [INW-1:0]  fft_data,
  output logic            fft_ready,
  output logic            rf_wr_en,
  output logic [REGW-1:0] rf_wr_reg,
  output logic [INW-1:0]  rf_wr_data,
  output logic            fft_forced,
  output logic [CNTW-1:0] conflict_cnt
);

  // starve_cnt never exceeds STARVE-1, and STARVE is at most 15.
  localparam int SW = 4;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE - 1);

  typedef enum logic [0:0] {
    S_ARB   = 1'b0,
    S_FORCE = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;

  logic pipe_req;
  logic same_reg;
  logic fft_grant;
  logic pipe_grant;

  // The arbitration decision for this cycle. Reset blocks both grants, so a
  // pending request is never accepted while rst_n is low.
  always_comb begin
    pipe_req   = pipe_valid & pipe_reg_wr_en;
    same_reg   = pipe_req & (pipe_wr_reg == fft_wr_reg);
    fft_grant  = rst_n & fft_valid &
                 (~pipe_req | (state == S_FORCE) | same_reg);
    pipe_grant = rst_n & pipe_req & ~fft_grant;
    fft_ready  = fft_grant;
    pipe_stall = pipe_req & fft_grant;
  end

  assign fft_forced = (state == S_FORCE);

  // Starvation FSM. ARB counts the FFT's lost cycles. FORCE lasts one cycle:
  // it grants a waiting result, or it gives up if fft_valid dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_ARB;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_ARB: begin
          if (fft_grant) begin
            starve_cnt <= '0;
          end else if (fft_valid) begin
            if (starve_cnt == STARVE_LAST) begin
              state      <= S_FORCE;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_FORCE: begin
          state      <= S_ARB;
          starve_cnt <= '0;
        end
        default: begin
          state      <= S_ARB;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Registered RF write port. Index and data hold their values when no
  // source is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end else if (fft_grant) begin
      rf_wr_en   <= 1'b1;
      rf_wr_reg  <= fft_wr_reg;
      rf_wr_data <= fft_data;
    end else if (pipe_grant) begin
      rf_wr_en   <= 1'b1;
      rf_wr_reg  <= pipe_wr_reg;
      rf_wr_data <= pipe_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

  // Saturating count of cycles in which both sources wanted the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (pipe_req && fft_valid && (conflict_cnt != {CNTW{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter. A table of per-cycle vectors holds the
// inputs, the expected combinational outputs and the expected RF write.
// Expected writes go into a queue when a vector is driven. They are popped
// and compared after the clock edge. The last block checks that the conflict
// counter saturates.
module tb_wb_port_arbiter;
  localparam int INW    = 32;
  localparam int REGW   = 3;
  localparam int STARVE = 4;
  localparam int CNTW   = 4;

  logic            clk;
  logic            rst_n;
  logic            pipe_valid;
  logic            pipe_reg_wr_en;
  logic [REGW-1:0] pipe_wr_reg;
  logic [INW-1:0]  pipe_data;
  logic            pipe_stall;
  logic            fft_valid;
  logic [REGW-1:0] fft_wr_reg;
  logic [INW-1:0]  fft_data;
  logic            fft_ready;
  logic            rf_wr_en;
  logic [REGW-1:0] rf_wr_reg;
  logic [INW-1:0]  rf_wr_data;
  logic            fft_forced;
  logic [CNTW-1:0] conflict_cnt;

  wb_port_arbiter #(
    .INW(INW), .REGW(REGW), .STARVE(STARVE), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_reg_wr_en(pipe_reg_wr_en),
    .pipe_wr_reg(pipe_wr_reg), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .fft_valid(fft_valid), .fft_wr_reg(fft_wr_reg), .fft_data(fft_data),
    .fft_ready(fft_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .fft_forced(fft_forced), .conflict_cnt(conflict_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst_n;
    logic            pv;
    logic            pw;
    logic [REGW-1:0] preg;
    logic [INW-1:0]  pdata;
    logic            fv;
    logic [REGW-1:0] freg;
    logic [INW-1:0]  fdata;
    logic            e_ready;
    logic            e_stall;
    logic            e_forced;
    logic            e_en;
    logic [REGW-1:0] e_reg;
    logic [INW-1:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  // {is_reset, wr_en, wr_reg, wr_data}
  logic [1+1+REGW+INW-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  logic [REGW-1:0] last_reg;
  logic [INW-1:0]  last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic pv, input logic pw,
                     input logic [REGW-1:0] preg, input logic [INW-1:0] pdata,
                     input logic fv, input logic [REGW-1:0] freg,
                     input logic [INW-1:0] fdata,
                     input logic er, input logic es, input logic ef,
                     input logic ee, input logic [REGW-1:0] ereg,
                     input logic [INW-1:0] edata);
    vec_t v;
    v.rst_n = r;  v.pv = pv; v.pw = pw; v.preg = preg; v.pdata = pdata;
    v.fv = fv;    v.freg = freg; v.fdata = fdata;
    v.e_ready = er; v.e_stall = es; v.e_forced = ef;
    v.e_en = ee;  v.e_reg = ereg; v.e_data = edata;
    vecs.push_back(v);
  endtask

  // Driver: apply one vector for one cycle, check the combinational outputs,
  // then check the registered write after the edge.
  task automatic step(input vec_t v, input int idx);
    logic [1+1+REGW+INW-1:0] e;
    @(negedge clk);
    rst_n = v.rst_n; pipe_valid = v.pv; pipe_reg_wr_en = v.pw;
    pipe_wr_reg = v.preg; pipe_data = v.pdata;
    fft_valid = v.fv; fft_wr_reg = v.freg; fft_data = v.fdata;
    #1;
    chk($sformatf("v%0d fft_ready", idx), 64'(fft_ready), 64'(v.e_ready));
    chk($sformatf("v%0d pipe_stall", idx), 64'(pipe_stall), 64'(v.e_stall));
    chk($sformatf("v%0d fft_forced", idx), 64'(fft_forced), 64'(v.e_forced));
    exp_q.push_back({~v.rst_n, v.e_en, v.e_reg, v.e_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e[1+1+REGW+INW-1]) begin
      last_reg = '0;
      last_data = '0;
      chk($sformatf("v%0d rf_wr_en", idx), 64'(rf_wr_en), 64'(0));
    end else begin
      chk($sformatf("v%0d rf_wr_en", idx), 64'(rf_wr_en), 64'(e[REGW+INW]));
      if (e[REGW+INW]) begin
        last_reg = e[REGW+INW-1:INW];
        last_data = e[INW-1:0];
      end
    end
    chk($sformatf("v%0d rf_wr_reg", idx), 64'(rf_wr_reg), 64'(last_reg));
    chk($sformatf("v%0d rf_wr_data", idx), 64'(rf_wr_data), 64'(last_data));
  endtask

  initial begin
    logic [REGW-1:0] rr;
    logic [INW-1:0]  rd;
    logic [CNTW-1:0] exp_cnt;

    rst_n = 1'b0; pipe_valid = 1'b0; pipe_reg_wr_en = 1'b0;
    pipe_wr_reg = '0; pipe_data = '0;
    fft_valid = 1'b0; fft_wr_reg = '0; fft_data = '0;
    last_reg = '0; last_data = '0;

    // rst pv pw preg pdata fv freg fdata | ready stall forced | en reg data
    // Reset with both requests present, then the pipe is granted first.
    add(0, 1, 1, 1, 32'h100, 1, 6, 32'h600, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 32'h100, 1, 6, 32'h600, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 32'h100, 1, 6, 32'h600, 0, 0, 0, 1, 1, 32'h100);
    add(1, 0, 0, 0, 32'h0,   1, 6, 32'h600, 1, 0, 0, 1, 6, 32'h600);
    // Pipe only, then idle and pipe valid without a register write.
    add(1, 1, 1, 5, 32'hA5,  0, 0, 32'h0,   0, 0, 0, 1, 5, 32'hA5);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 7, 32'h77,  0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 7, 32'h77,  1, 3, 32'h33,  1, 0, 0, 1, 3, 32'h33);
    // Same register: the FFT result lands first, then the pipe value.
    add(1, 1, 1, 4, 32'h11,  1, 4, 32'h22,  1, 1, 0, 1, 4, 32'h22);
    add(1, 1, 1, 4, 32'h11,  0, 0, 32'h0,   0, 0, 0, 1, 4, 32'h11);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    // Starvation: four lost cycles, then a forced grant. Two rounds.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < STARVE; i++)
        add(1, 1, 1, 2, 32'h200, 1, 3, 32'h300 + r, 0, 0, 0, 1, 2, 32'h200);
      add(1, 1, 1, 2, 32'h200, 1, 3, 32'h300 + r, 1, 1, 1, 1, 3, 32'h300 + r);
    end
    add(1, 1, 1, 2, 32'h200, 0, 0, 32'h0,   0, 0, 0, 1, 2, 32'h200);
    // FFT withdraws while forced: FORCE is abandoned and counting restarts.
    for (int i = 0; i < STARVE; i++)
      add(1, 1, 1, 2, 32'h222, 1, 5, 32'h555, 0, 0, 0, 1, 2, 32'h222);
    add(1, 1, 1, 2, 32'h222, 0, 5, 32'h555, 0, 0, 1, 1, 2, 32'h222);
    for (int i = 0; i < STARVE; i++)
      add(1, 1, 1, 2, 32'h222, 1, 5, 32'h555, 0, 0, 0, 1, 2, 32'h222);
    // Reset while in FORCE: the forced grant is discarded.
    add(0, 1, 1, 2, 32'h222, 1, 5, 32'h555, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 2, 32'h222, 1, 5, 32'h555, 0, 0, 0, 1, 2, 32'h222);
    // Reset with a lone FFT request pending: no write after reset.
    add(0, 0, 0, 0, 32'h0,   1, 1, 32'h111, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    // Random pipe-only writes.
    for (int i = 0; i < 4; i++) begin
      rr = REGW'($urandom_range(0, 7));
      rd = $urandom;
      add(1, 1, 1, rr, rd, 0, 0, 32'h0, 0, 0, 0, 1, rr, rd);
    end

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Conflict counter: reset, then 2^CNTW+3 conflict cycles.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("conflict_cnt reset", 64'(conflict_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < (1 << CNTW) + 3; i++) begin
      pipe_valid = 1'b1; pipe_reg_wr_en = 1'b1; pipe_wr_reg = 3'd1;
      pipe_data = $urandom;
      fft_valid = 1'b1; fft_wr_reg = 3'd2; fft_data = $urandom;
      @(posedge clk);
      #1;
      if (exp_cnt != {CNTW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("conflict_cnt c%0d", i), 64'(conflict_cnt), 64'(exp_cnt));
      @(negedge clk);
    end
    chk("conflict_cnt saturated", 64'(conflict_cnt), 64'({CNTW{1'b1}}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
